backup_ram_ctrl: RTL and testbench

BACKUP_RAM_CTRL -- requirements
Module: backup_ram_ctrl

---
 rtl/backup_ram_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_backup_ram_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/backup_ram_ctrl.sv
// Backup (battery) RAM controller: moves cartridge save RAM between the
// SD image and on-board RAM, one 512-byte sector per SD handshake.
module backup_ram_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,

    input  logic              img_mounted,
    input  logic              img_readonly,
    input  logic [63:0]       img_size,

    input  logic              bk_load,
    input  logic              bk_save,
    input  logic              osd_status,
    input  logic              autosave_en,

    input  logic [7:0]        ram_size_code,
    input  logic              cart_ram_wr,

    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic [15:0]       sd_buff_din,

    input  logic              sd_ack,
    input  logic [7:0]        sd_buff_addr,
    input  logic [15:0]       sd_buff_dout,
    input  logic              sd_buff_wr,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,

    output logic              busy,
    output logic              loading,
    output logic              sav_pending
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_XFER,
        WR_REQ,
        WR_XFER
    } state_t;

    state_t      state;
    logic [8:0]  sec_idx;
    logic [8:0]  sec_cnt;
    logic        ack_q;
    logic        osd_q;

    logic [8:0]  n_sec;
    logic [31:0] img_sec;
    logic [8:0]  eff_cnt;
    logic [8:0]  sec_next;
    logic        sec_last;
    logic        ack_rise;
    logic        ack_fall;
    logic        load_req;
    logic        save_req;
    logic        load_go;
    logic        save_go;
    logic        xfer;
    logic        xfer_done;
    logic [15:0] xfer_addr;

    always_comb begin
        n_sec = 9'd0;
        case (ram_size_code)
            8'd1:    n_sec = 9'd4;
            8'd2:    n_sec = 9'd16;
            8'd3:    n_sec = 9'd64;
            8'd4:    n_sec = 9'd256;
            8'd5:    n_sec = 9'd128;
            default: n_sec = 9'd0;
        endcase
    end

    // A short image limits how many sectors a load may read.
    assign img_sec = img_size[40:9];
    assign eff_cnt = (img_sec < {23'd0, n_sec}) ? img_sec[8:0] : n_sec;

    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;

    assign load_req = bk_load | (img_mounted & (img_size != 64'd0));
    assign save_req = bk_save
                    | (osd_q & ~osd_status & autosave_en & sav_pending);

    assign load_go = load_req & (eff_cnt != 9'd0);
    assign save_go = save_req & ~load_req
                   & (n_sec != 9'd0) & ~img_readonly;

    // 9-bit index so a 256-sector transfer ends at 255 instead of wrapping.
    assign sec_next = sec_idx + 9'd1;
    assign sec_last = (sec_next == sec_cnt);

    assign xfer      = (state == RD_XFER) || (state == WR_XFER);
    assign xfer_done = xfer & ack_fall & sec_last;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
            osd_q <= 1'b0;
        end else begin
            ack_q <= sd_ack;
            osd_q <= osd_status;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sec_idx <= 9'd0;
            sec_cnt <= 9'd0;
            sd_lba  <= 32'd0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_go) begin
                        state   <= RD_REQ;
                        sec_idx <= 9'd0;
                        sec_cnt <= eff_cnt;
                        sd_lba  <= 32'd0;
                        sd_rd   <= 1'b1;
                    end else if (save_go) begin
                        state   <= WR_REQ;
                        sec_idx <= 9'd0;
                        sec_cnt <= n_sec;
                        sd_lba  <= 32'd0;
                        sd_wr   <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (ack_rise) begin
                        sd_rd <= 1'b0;
                        state <= RD_XFER;
                    end
                end
                RD_XFER: begin
                    if (ack_fall) begin
                        sec_idx <= sec_next;
                        if (sec_last) begin
                            state <= IDLE;
                        end else begin
                            state  <= RD_REQ;
                            sd_lba <= {23'd0, sec_next};
                            sd_rd  <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (ack_rise) begin
                        sd_wr <= 1'b0;
                        state <= WR_XFER;
                    end
                end
                WR_XFER: begin
                    if (ack_fall) begin
                        sec_idx <= sec_next;
                        if (sec_last) begin
                            state <= IDLE;
                        end else begin
                            state  <= WR_REQ;
                            sd_lba <= {23'd0, sec_next};
                            sd_wr  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sd_rd <= 1'b0;
                    sd_wr <= 1'b0;
                end
            endcase
        end
    end

    // A game write landing on the completing cycle keeps the flag set.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sav_pending <= 1'b0;
        end else if (cart_ram_wr && !loading) begin
            sav_pending <= 1'b1;
        end else if (xfer_done) begin
            sav_pending <= 1'b0;
        end
    end

    assign busy    = (state != IDLE);
    assign loading = (state == RD_REQ) || (state == RD_XFER);

    assign xfer_addr   = {sec_idx[7:0], sd_buff_addr};
    assign ram_addr    = xfer ? ADDR_W'(xfer_addr) : '0;
    assign ram_we      = (state == RD_XFER) & sd_buff_wr;
    assign ram_wdata   = sd_buff_dout;
    assign sd_buff_din = (state == WR_XFER) ? ram_rdata : 16'd0;

endmodule

// File: tb/tb_backup_ram_ctrl.sv
// Directed bench for backup_ram_ctrl with an SD host model and a
// one-cycle-latency RAM model.
module tb_backup_ram_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        bk_load, bk_save, osd_status, autosave_en;
    logic [7:0]  ram_size_code;
    logic        cart_ram_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic [15:0] sd_buff_din;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy, loading, sav_pending;

    int passed = 0;
    int total  = 0;

    backup_ram_ctrl #(.ADDR_W(16)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size      (img_size),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .osd_status    (osd_status),
        .autosave_en   (autosave_en),
        .ram_size_code (ram_size_code),
        .cart_ram_wr   (cart_ram_wr),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_buff_din   (sd_buff_din),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .busy          (busy),
        .loading       (loading),
        .sav_pending   (sav_pending)
    );

    always #5 clk_sys = ~clk_sys;

    logic [15:0] mem [0:65535];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int   rd_cnt = 0, wr_cnt = 0, we_cnt = 0, we_bad = 0;
    logic rd_q = 1'b0, wr_q = 1'b0;
    always @(posedge clk_sys) begin
        rd_q <= sd_rd;
        wr_q <= sd_wr;
        if (sd_rd && !rd_q) rd_cnt <= rd_cnt + 1;
        if (sd_wr && !wr_q) wr_cnt <= wr_cnt + 1;
        if (ram_we) we_cnt <= we_cnt + 1;
        if (ram_we && ram_addr > 16'h0FFF) we_bad <= we_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_req(input bit is_wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (is_wr ? sd_wr : sd_rd) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("req_timeout", {31'd0, is_wr ? sd_wr : sd_rd}, 1);
    endtask

    function automatic logic [15:0] pat(input int lba, input int w);
        logic [7:0] l8, w8;
        l8 = lba[7:0];
        w8 = w[7:0];
        return {l8, w8} ^ 16'h5A3C;
    endfunction

    task automatic serve(input bit is_wr, input int lba, input int nwords,
                         input bit chk_din, input bit wr_on_done);
        bit ok;
        int bad;
        wait_req(is_wr, ok);
        if (!ok) return;
        chk("lba", sd_lba, lba);
        tick();
        sd_ack = 1'b1;
        tick();
        chk("req_drop", {31'd0, is_wr ? sd_wr : sd_rd}, 0);
        bad = 0;
        for (int i = 0; i < nwords; i++) begin
            sd_buff_addr = i[7:0];
            sd_buff_dout = pat(lba, i);
            sd_buff_wr   = !is_wr;
            tick();
            if (is_wr && chk_din && sd_buff_din !== pat(lba, i)) bad++;
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        if (wr_on_done) cart_ram_wr = 1'b1;
        tick();
        cart_ram_wr = 1'b0;
        if (is_wr && chk_din) chk("din", bad, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  r0, w0, e0, bad;
        bit  ok;
        reset_n = 0; img_mounted = 0; img_readonly = 0; img_size = 0;
        bk_load = 0; bk_save = 0; osd_status = 0; autosave_en = 0;
        ram_size_code = 0; cart_ram_wr = 0; sd_ack = 0;
        sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_loading", loading, 0);
        chk("rst_pending", sav_pending, 0);
        chk("rst_rd", sd_rd, 0);
        chk("rst_wr", sd_wr, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", sd_buff_din, 0);
        reset_n = 1;
        tick(2);

        // Load 16 sectors; save issued with the load and during it.
        cart_ram_wr = 1; tick(); cart_ram_wr = 0;
        chk("pend_set", sav_pending, 1);
        ram_size_code = 8'd2;
        img_size = 64'd8192;
        r0 = rd_cnt; w0 = wr_cnt; e0 = we_cnt;
        bk_load = 1; bk_save = 1; tick(); bk_load = 0; bk_save = 0;
        chk("ld_busy", busy, 1);
        chk("ld_loading", loading, 1);
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                bk_save = 1; tick(); bk_save = 0;
            end
            serve(0, k, 256, 0, 0);
        end
        chk("ld_busy_end", busy, 0);
        chk("ld_rd_cnt", rd_cnt - r0, 16);
        chk("ld_we_cnt", we_cnt - e0, 4096);
        chk("ld_addr_range", we_bad, 0);
        chk("ld_pend_clr", sav_pending, 0);
        bad = 0;
        for (int a = 0; a < 4096; a++)
            if (mem[a] !== (a[15:0] ^ 16'h5A3C)) bad++;
        chk("ld_mem", bad, 0);
        tick(5);
        chk("ld_no_save", wr_cnt - w0, 0);

        // Short image: 1024 bytes limits a 64-sector cart to 2 sectors.
        ram_size_code = 8'd3;
        img_size = 64'd1024;
        r0 = rd_cnt;
        img_mounted = 1; tick(); img_mounted = 0;
        serve(0, 0, 256, 0, 0);
        serve(0, 1, 256, 0, 0);
        tick(20);
        chk("short_rd_cnt", rd_cnt - r0, 2);
        chk("short_busy", busy, 0);
        img_size = 64'd0;
        img_mounted = 1; tick(); img_mounted = 0;
        tick(3);
        chk("empty_mount", busy, 0);

        // Save with a write-protected image, then a writable one.
        ram_size_code = 8'd1;
        img_size = 64'd2048;
        img_readonly = 1;
        cart_ram_wr = 1; tick(); cart_ram_wr = 0;
        w0 = wr_cnt;
        bk_save = 1; tick(); bk_save = 0;
        tick(10);
        chk("ro_busy", busy, 0);
        chk("ro_wr_cnt", wr_cnt - w0, 0);
        img_readonly = 0;
        bk_save = 1; tick(); bk_save = 0;
        chk("sv_busy", busy, 1);
        for (int k = 0; k < 4; k++) serve(1, k, 256, 1, 0);
        chk("sv_busy_end", busy, 0);
        chk("sv_wr_cnt", wr_cnt - w0, 4);
        chk("sv_pend_clr", sav_pending, 0);

        // Autosave on OSD close, first with nothing pending.
        autosave_en = 1;
        w0 = wr_cnt;
        osd_status = 1; tick(2); osd_status = 0;
        tick(10);
        chk("as_idle_wr", wr_cnt - w0, 0);
        chk("as_idle_busy", busy, 0);
        cart_ram_wr = 1; tick(); cart_ram_wr = 0;
        osd_status = 1; tick(2); osd_status = 0;
        for (int k = 0; k < 4; k++) serve(1, k, 256, 1, k == 3);
        chk("as_wr_cnt", wr_cnt - w0, 4);
        chk("as_set_wins", sav_pending, 1);

        // 256-sector save ends at lba 255 with no wrap.
        autosave_en = 0;
        ram_size_code = 8'd4;
        w0 = wr_cnt;
        bk_save = 1; tick(); bk_save = 0;
        for (int k = 0; k < 256; k++) serve(1, k, 2, 0, 0);
        chk("n256_busy", busy, 0);
        tick(20);
        chk("n256_wr_cnt", wr_cnt - w0, 256);
        chk("n256_wr_low", sd_wr, 0);
        chk("n256_pend_clr", sav_pending, 0);

        // Reset asserted in the middle of sector 3 of a load.
        ram_size_code = 8'd2;
        img_size = 64'd8192;
        bk_load = 1; tick(); bk_load = 0;
        for (int k = 0; k < 3; k++) serve(0, k, 256, 0, 0);
        wait_req(0, ok);
        chk("rst3_lba", sd_lba, 3);
        tick();
        sd_ack = 1; tick();
        sd_buff_addr = 8'd5; sd_buff_wr = 1;
        tick(2);
        reset_n = 0;
        #1;
        chk("rst3_rd", sd_rd, 0);
        chk("rst3_busy", busy, 0);
        chk("rst3_we", ram_we, 0);
        e0 = we_cnt;
        tick(2);
        chk("rst3_no_write", we_cnt - e0, 0);
        sd_ack = 0; sd_buff_wr = 0;
        reset_n = 1;
        tick(2);
        chk("rst3_idle", busy, 0);
        chk("rst3_lba0", sd_lba, 0);
        chk("rst3_addr0", ram_addr, 0);
        bk_load = 1; tick(); bk_load = 0;
        serve(0, 0, 256, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
